tank_motion: RTL and testbench
==============================

// Module: tank_motion
// PURPOSE
//  Per-frame pose generator for one tank. Runs on the system clock and is advanced by the VGA frame clock (vsync).
//  Produces the tank centre (TankX, TankY) and the heading sine/cosine (sin_q, cos_q) consumed directly by color_mapper.
//  Inputs are four decoded movement controls from the keyboard decode stage.
// PARAMETERS
//  START_X  320  reset X position, pixels
//  START_Y  240  reset Y position, pixels
//  X_MIN    16   smallest legal X, pixels
//  X_MAX    623  largest legal X, pixels
//  Y_MIN    16   smallest legal Y, pixels
//  Y_MAX    463  largest legal Y, pixels
//  SPEED    2    pixels per frame at unit heading (4-bit, 1..15)
// PORTS
//  Clk         in   1   system clock
//  Reset       in   1   synchronous active-high reset
//  frame_clk   in   1   VGA vsync, asynchronous to Clk
//  fwd         in   1   move along the heading
//  back        in   1   move against the heading
//  rot_l       in   1   rotate counter-clockwise by one step
//  rot_r       in   1   rotate clockwise by one step
//  TankX       out  10  tank centre X, pixels
//  TankY       out  10  tank centre Y, pixels
//  sin_q       out  8   signed Q3.4 sine of the heading
//  cos_q       out  8   signed Q3.4 cosine of the heading
//  frame_done  out  1   one-Clk pulse when a new pose has been committed
// BEHAVIOUR
//  - Clocking: one clock, Clk. Reset is synchronous and active-high.
//  - Reset values:
//    - TankX=START_X, TankY=START_Y.
//    - angle=0, so cos_q=8'sd16 and sin_q=0.
//    - frame_done=0. FSM in IDLE.
//  - Frame tick: frame_clk passes through a 2-flop synchronizer. A rising edge of the synchronized signal gives a one-cycle tick.
//  - FSM: IDLE -> ROTATE -> MOVE -> CLAMP -> COMMIT -> IDLE. One cycle per state.
//    - IDLE: wait for tick. Leave on tick.
//    - ROTATE: angle is 4 bits, 16 steps of 22.5 deg, increasing clockwise on screen.
//      - rot_r & !rot_l: angle+1, wrapping 15->0.
//      - rot_l & !rot_r: angle-1, wrapping 0->15.
//      - Both or neither: angle unchanged.
//    - MOVE: dir=+1 if fwd&!back, -1 if back&!fwd, else 0.
//      - px += dir*SPEED*cos(angle); py += dir*SPEED*sin(angle).
//      - Arithmetic is signed 16-bit on 10.4 fixed-point positions. The fraction is kept across frames.
//    - CLAMP: out-of-range positions are forced to the bound (e.g. px < X_MIN<<4 becomes X_MIN<<4). Fraction is zeroed on clamp.
//    - COMMIT: TankX=px[13:4], TankY=py[13:4], sin_q/cos_q from the new angle. frame_done=1 for this cycle.
//  - Latency: outputs change exactly 4 Clk after the tick cycle. All outputs are registered and change only in COMMIT, so there is no pose tearing.
//  - Controls are sampled in ROTATE and MOVE only; their value in other cycles is ignored.
//  - A tick arriving while not in IDLE is dropped. This cannot happen at real frame rates.
//  - Reset in any state returns to IDLE with reset values. The in-flight update is discarded.
//  - Trig table, Q3.4 (16 = 1.0), index 0..15:
//    - cos: 16,15,11,6,0,-6,-11,-15,-16,-15,-11,-6,0,6,11,15
//    - sin: cos shifted by 4 (sin[k]=cos[(k+12)%16]).
// CONFIGURATION
//  TANK_TORUS_WRAP_EN
//  - Undefined: CLAMP saturates at the bounds, as described above.
//  - Defined: a position past X_MAX re-enters at X_MIN + overshoot, and one below X_MIN re-enters at X_MAX - undershoot. Y behaves the same.
//    The fraction is kept. At most one wrap per frame, since SPEED < span.
// STRUCTURE
//  Package tank_pkg:
//  - angle_t (logic [3:0]); trig_t (logic signed [7:0]); pos_t (logic [13:0], 10.4).
//  - Constants TRIG_ONE=16 and FRAC_BITS=4.
//  - The 16-entry COS_LUT constant and functions cos_of(angle_t) / sin_of(angle_t).
//  Sub-module trig_lut: registered angle -> {sin_q, cos_q} lookup, reused by the turret/bullet stage.
//  The FSM, synchronizer and position datapath stay in tank_motion.
// TESTING
//  1 Reset, defaults -> TankX=320, TankY=240, cos_q=16, sin_q=0, frame_done=0.
//  2 fwd=1, one frame_clk edge, angle 0 -> frame_done 4 Clk after tick; TankX=322, TankY=240.
//  3 rot_r=1, one tick -> cos_q=15, sin_q=6, position unchanged.
//    Then rot_l=1 twice -> cos_q=15, sin_q=-6 (angle 15, wrap).
//  4 fwd=back=1 and rot_l=rot_r=1 for 3 ticks -> pose unchanged, frame_done pulses 3 times.
//  5 From X=622, angle 0, fwd, 2 ticks:
//    - default build -> TankX=623 after each tick.
//    - TANK_TORUS_WRAP_EN build -> TankX=16+(624-623)=17 on the first crossing.
//  6 Assert Reset during MOVE state -> next cycle IDLE. TankX=320, angle=0, no frame_done pulse.

Source files
------------

// File: rtl/tank_pkg.sv
// tank_pkg: shared types, fixed-point constants and the heading trig table.
//   angle_t : 4-bit heading, 16 steps of 22.5 deg, increasing clockwise on screen
//   trig_t  : signed Q3.4 sine/cosine (TRIG_ONE = 1.0)
//   pos_t   : unsigned 10.4 fixed-point screen position
package tank_pkg;
    typedef logic [3:0] angle_t;
    typedef logic signed [7:0] trig_t;
    typedef logic [13:0] pos_t;
    typedef enum logic [2:0] {IDLE, ROTATE, MOVE, CLAMP, COMMIT} state_t;
    localparam int TRIG_ONE = 16;
    localparam int FRAC_BITS = 4;
    localparam trig_t COS_LUT [16] = '{
        8'sd16, 8'sd15, 8'sd11, 8'sd6, 8'sd0, -8'sd6, -8'sd11, -8'sd15,
        -8'sd16, -8'sd15, -8'sd11, -8'sd6, 8'sd0, 8'sd6, 8'sd11, 8'sd15
    };
    function automatic trig_t cos_of(input angle_t a);
        return COS_LUT[a];
    endfunction
    // sine is the cosine table a quarter turn behind; the 4-bit add wraps mod 16
    function automatic trig_t sin_of(input angle_t a);
        angle_t k;
        k = a + 4'd12;
        return COS_LUT[k];
    endfunction
endpackage

// File: rtl/tank_trig_lut.sv
// trig_lut: registered heading -> {sin_q, cos_q} lookup, updated only when load is high.
//   Clk, Reset : system clock, synchronous active-high reset (heading 0: cos=1.0, sin=0)
//   load       : capture the trig values of angle on this edge
//   angle      : heading to look up
//   sin_q/cos_q: registered Q3.4 sine/cosine
module trig_lut
    import tank_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset,
    input  logic   load,
    input  angle_t angle,
    output trig_t  sin_q,
    output trig_t  cos_q
);
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sin_q <= '0;
            cos_q <= trig_t'(TRIG_ONE);
        end else if (load) begin
            sin_q <= sin_of(angle);
            cos_q <= cos_of(angle);
        end
    end
endmodule

// File: rtl/tank_motion.sv
// tank_motion: per-frame pose generator for one tank, advanced by the VGA vsync.
//   Clk, Reset         : system clock, synchronous active-high reset
//   frame_clk          : vsync, asynchronous to Clk (2-flop synchronized)
//   fwd, back          : move along / against the heading
//   rot_l, rot_r       : rotate counter-clockwise / clockwise by one step
//   TankX, TankY       : registered tank centre, pixels
//   sin_q, cos_q       : registered Q3.4 heading sine/cosine
//   frame_done         : high for the one cycle in which a new pose is first visible
// Build option TANK_TORUS_WRAP_EN: positions wrap around the play field instead of saturating.
module tank_motion
    import tank_pkg::*;
#(
    parameter int START_X = 320,
    parameter int START_Y = 240,
    parameter int X_MIN   = 16,
    parameter int X_MAX   = 623,
    parameter int Y_MIN   = 16,
    parameter int Y_MAX   = 463,
    parameter int SPEED   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fwd,
    input  logic       back,
    input  logic       rot_l,
    input  logic       rot_r,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output trig_t      sin_q,
    output trig_t      cos_q,
    output logic       frame_done
);
    localparam logic signed [15:0] SPD  = 16'(SPEED);
    localparam logic signed [15:0] X_LO = 16'(X_MIN << FRAC_BITS);
    localparam logic signed [15:0] X_HI = 16'(X_MAX << FRAC_BITS);
    localparam logic signed [15:0] Y_LO = 16'(Y_MIN << FRAC_BITS);
    localparam logic signed [15:0] Y_HI = 16'(Y_MAX << FRAC_BITS);
    localparam logic signed [15:0] PX0  = 16'(START_X << FRAC_BITS);
    localparam logic signed [15:0] PY0  = 16'(START_Y << FRAC_BITS);

    function automatic logic signed [15:0] bound(
        input logic signed [15:0] p,
        input logic signed [15:0] lo,
        input logic signed [15:0] hi
    );
`ifdef TANK_TORUS_WRAP_EN
        // re-enter from the opposite edge carrying the overshoot and fraction
        return p > hi ? p - hi + lo : p < lo ? hi - (lo - p) : p;
`else
        return p > hi ? hi : p < lo ? lo : p;
`endif
    endfunction

    logic [2:0] fsync;
    logic tick;
    state_t state;
    angle_t angle;
    logic signed [15:0] px, py, cx, sy, vx, vy, bx, by;

    // fsync[1] is the synchronized vsync, fsync[2] its previous value
    assign tick = fsync[1] & ~fsync[2];

    always_comb begin
        cx = 16'(cos_of(angle));
        sy = 16'(sin_of(angle));
        vx = (fwd & ~back) ? SPD * cx : (back & ~fwd) ? -(SPD * cx) : '0;
        vy = (fwd & ~back) ? SPD * sy : (back & ~fwd) ? -(SPD * sy) : '0;
        bx = bound(px, X_LO, X_HI);
        by = bound(py, Y_LO, Y_HI);
    end

    // outputs are loaded on the edge into COMMIT, so the whole pose appears
    // together in the cycle frame_done is high
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync      <= '0;
            state      <= IDLE;
            angle      <= '0;
            px         <= PX0;
            py         <= PY0;
            TankX      <= 10'(START_X);
            TankY      <= 10'(START_Y);
            frame_done <= 1'b0;
        end else begin
            fsync      <= {fsync[1:0], frame_clk};
            frame_done <= 1'b0;
            case (state)
                IDLE:   state <= tick ? ROTATE : IDLE;
                ROTATE: begin
                    angle <= (rot_r & ~rot_l) ? angle + 4'd1 :
                             (rot_l & ~rot_r) ? angle - 4'd1 : angle;
                    state <= MOVE;
                end
                MOVE: begin
                    px    <= px + vx;
                    py    <= py + vy;
                    state <= CLAMP;
                end
                CLAMP: begin
                    px         <= bx;
                    py         <= by;
                    TankX      <= bx[13:4];
                    TankY      <= by[13:4];
                    frame_done <= 1'b1;
                    state      <= COMMIT;
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    trig_lut u_trig (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (state == CLAMP),
        .angle (angle),
        .sin_q (sin_q),
        .cos_q (cos_q)
    );
endmodule

// File: tb/tb_tank_motion.sv
// tb_tank_motion: directed self-checking bench for tank_motion.
module tb_tank_motion;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk = 1'b0;
    logic fwd = 1'b0, back = 1'b0, rot_l = 1'b0, rot_r = 1'b0;
    logic [9:0] TankX, TankY;
    logic signed [7:0] sin_q, cos_q;
    logic frame_done;
    int checks = 0;
    int passed = 0;

    tank_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .fwd        (fwd),
        .back       (back),
        .rot_l      (rot_l),
        .rot_r      (rot_r),
        .TankX      (TankX),
        .TankY      (TankY),
        .sin_q      (sin_q),
        .cos_q      (cos_q),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    // raise vsync, count edges until frame_done (20 = timed out), note frame_done one edge later
    task automatic do_frame(output int lat, output logic after);
        frame_clk = 1'b1;
        lat = 0;
        while (lat < 20 && frame_done !== 1'b1) begin
            @(posedge Clk); #1;
            lat++;
        end
        @(posedge Clk); #1;
        after = frame_done;
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checks++; if (TankX !== 10'd320) $display("FAIL reset_x got %0d want 320", TankX); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL reset_y got %0d want 240", TankY); else passed++;
        checks++; if (cos_q !== 8'sd16) $display("FAIL reset_cos got %0d want 16", cos_q); else passed++;
        checks++; if (sin_q !== 8'sd0) $display("FAIL reset_sin got %0d want 0", sin_q); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else passed++;
    endtask

    task automatic test_forward();
        int lat;
        logic after;
        fwd = 1'b1;
        do_frame(lat, after);
        fwd = 1'b0;
        checks++; if (lat !== 6) $display("FAIL fwd_latency got %0d edges want 6", lat); else passed++;
        checks++; if (after !== 1'b0) $display("FAIL fwd_pulse_width got %b want 0", after); else passed++;
        checks++; if (TankX !== 10'd322) $display("FAIL fwd_x got %0d want 322", TankX); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL fwd_y got %0d want 240", TankY); else passed++;
        checks++; if (cos_q !== 8'sd16) $display("FAIL fwd_cos got %0d want 16", cos_q); else passed++;
    endtask

    task automatic test_rotate();
        int lat;
        logic after;
        rot_r = 1'b1;
        do_frame(lat, after);
        rot_r = 1'b0;
        checks++; if (cos_q !== 8'sd15) $display("FAIL rot_r_cos got %0d want 15", cos_q); else passed++;
        checks++; if (sin_q !== 8'sd6) $display("FAIL rot_r_sin got %0d want 6", sin_q); else passed++;
        checks++; if (TankX !== 10'd322) $display("FAIL rot_r_x got %0d want 322", TankX); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL rot_r_y got %0d want 240", TankY); else passed++;
        rot_l = 1'b1;
        do_frame(lat, after);
        do_frame(lat, after);
        rot_l = 1'b0;
        checks++; if (cos_q !== 8'sd15) $display("FAIL rot_wrap_cos got %0d want 15", cos_q); else passed++;
        checks++; if (sin_q !== -8'sd6) $display("FAIL rot_wrap_sin got %0d want -6", sin_q); else passed++;
        rot_r = 1'b1;
        do_frame(lat, after);
        rot_r = 1'b0;
        checks++; if (cos_q !== 8'sd16) $display("FAIL rot_back_cos got %0d want 16", cos_q); else passed++;
        checks++; if (sin_q !== 8'sd0) $display("FAIL rot_back_sin got %0d want 0", sin_q); else passed++;
    endtask

    task automatic test_conflict();
        int lat;
        logic after;
        int pulses = 0;
        fwd = 1'b1; back = 1'b1; rot_l = 1'b1; rot_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_frame(lat, after);
            if (lat < 20) pulses++;
        end
        fwd = 1'b0; back = 1'b0; rot_l = 1'b0; rot_r = 1'b0;
        checks++; if (pulses !== 3) $display("FAIL conflict_pulses got %0d want 3", pulses); else passed++;
        checks++; if (TankX !== 10'd322) $display("FAIL conflict_x got %0d want 322", TankX); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL conflict_y got %0d want 240", TankY); else passed++;
        checks++; if (cos_q !== 8'sd16) $display("FAIL conflict_cos got %0d want 16", cos_q); else passed++;
        checks++; if (sin_q !== 8'sd0) $display("FAIL conflict_sin got %0d want 0", sin_q); else passed++;
    endtask

    task automatic test_edge();
        int lat;
        logic after;
        logic [9:0] exp1, exp2;
`ifdef TANK_TORUS_WRAP_EN
        exp1 = 10'd17;
        exp2 = 10'd19;
`else
        exp1 = 10'd623;
        exp2 = 10'd623;
`endif
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        fwd = 1'b1;
        for (int i = 0; i < 151; i++) do_frame(lat, after);
        checks++; if (TankX !== 10'd622) $display("FAIL edge_setup_x got %0d want 622", TankX); else passed++;
        do_frame(lat, after);
        checks++; if (TankX !== exp1) $display("FAIL edge_x1 got %0d want %0d", TankX, exp1); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL edge_y1 got %0d want 240", TankY); else passed++;
        do_frame(lat, after);
        fwd = 1'b0;
        checks++; if (TankX !== exp2) $display("FAIL edge_x2 got %0d want %0d", TankX, exp2); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL edge_y2 got %0d want 240", TankY); else passed++;
    endtask

    task automatic test_reset_in_move();
        int seen = 0;
        fwd = 1'b1; rot_r = 1'b1;
        frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (dut.state !== tank_pkg::MOVE) $display("FAIL mid_state got %0d want MOVE", dut.state); else passed++;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        checks++; if (dut.state !== tank_pkg::IDLE) $display("FAIL rst_state got %0d want IDLE", dut.state); else passed++;
        checks++; if (TankX !== 10'd320) $display("FAIL rst_x got %0d want 320", TankX); else passed++;
        checks++; if (TankY !== 10'd240) $display("FAIL rst_y got %0d want 240", TankY); else passed++;
        checks++; if (cos_q !== 8'sd16) $display("FAIL rst_cos got %0d want 16", cos_q); else passed++;
        checks++; if (sin_q !== 8'sd0) $display("FAIL rst_sin got %0d want 0", sin_q); else passed++;
        for (int i = 0; i < 10; i++) begin
            if (frame_done === 1'b1) seen++;
            @(posedge Clk); #1;
        end
        fwd = 1'b0; rot_r = 1'b0;
        checks++; if (seen !== 0) $display("FAIL rst_no_done got %0d pulses want 0", seen); else passed++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_rotate();
        test_conflict();
        test_edge();
        test_reset_in_move();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
